fibonacci_checker: RTL and testbench
====================================

Name: fibonacci_checker

Overview:
- Consumer-side counterpart of our Fibonacci term generator. It takes a stream of WIDTH-bit terms over a valid/ready interface and locks onto the seed pair 1,1.
- Once locked, it checks every following term against the recurrence t(n) = t(n-1) + t(n-2), taken mod 2^WIDTH.
- It counts accepted terms and mismatches, and stops taking data on the first fault until software clears it.
- It sits at the generator output as a self-check and test monitor.

Parameters:
- WIDTH, 17, width of one term; sums wrap mod 2^WIDTH.
- CNT_W, 16, width of term_count and err_count; both counters saturate.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (reset = 0 resets the block).
- in_valid  input  1  in_data holds a term.
- in_data  input  WIDTH  incoming term.
- in_ready  output  1  checker can accept a term this cycle.
- clear  input  1  synchronous restart to HUNT.
- locked  output  1  seed pair found, sequence being tracked.
- err  output  1  sticky mismatch flag.
- expected  output  WIDTH  next term the checker requires.
- term_count  output  CNT_W  terms accepted in the current locked run.
- err_count  output  CNT_W  total mismatches since reset.

Behaviour:
- Accept rule: a term is accepted on a rising edge where in_valid && in_ready.
- in_ready = (state != FAULT) && !clear. This is combinational from clear, so clear takes priority and no beat is accepted in a clear cycle.
- Reset (reset = 0, no clock edge needed) sets:
  - state = HUNT;
  - a, b, expected, term_count, err_count = 0;
  - locked = 0, err = 0.
  - in_ready reads 1 once reset is released.
- State HUNT:
  - accepted 1 -> SEED;
  - any other accepted value stays in HUNT.
- State SEED:
  - accepted 1 -> TRACK, with a = 1, b = 1, term_count = 2, locked = 1;
  - any other accepted value -> HUNT.
- State TRACK:
  - expected = (a + b) mod 2^WIDTH. It is registered, so it updates the cycle after each accept.
  - Accepted term == expected: a <= b, b <= in_data, term_count += 1, saturating at all-ones.
  - Accepted term != expected: -> FAULT, err = 1, locked = 0, err_count += 1 (saturating). a, b and term_count are frozen.
- State FAULT:
  - in_ready = 0; everything holds until clear.
- clear (any state, one clock):
  - state = HUNT; a, b, expected, term_count = 0; locked = 0; err = 0.
  - err_count is preserved.
- Outside TRACK, expected reads 0.
- Idle cycles (in_valid = 0) change nothing. Gaps between beats are legal and do not affect checking.
- Wrap: the sum drops its carry (WIDTH-bit adder, no overflow flag). Wrapped values are correct terms, not errors.
- Latency: flags and counters reflect a beat on the cycle after it is accepted.
- Async reset asserted mid-operation: all outputs clear immediately, and any in-flight beat is dropped.

Test Plan:
- Basic lock: release reset, stream 1,1,2,3,5,8 back-to-back -> locked = 1 after beat 2; after beat 6, term_count = 6, expected = 13, err = 0, err_count = 0.
- Hunting: stream 7,1,4,1,1,2 -> locked stays 0 through beat 4 and rises after beat 5; term_count = 3 after beat 6.
- Fault:
  - stream 1,1,2,4 -> after beat 4, err = 1, locked = 0, err_count = 1, in_ready = 0; in_ready stays 0 for 10 cycles despite in_valid = 1.
  - Pulse clear -> HUNT, err = 0, err_count stays 1.
  - Re-stream 1,1,2 -> term_count = 3.
- Wrap (WIDTH = 17): stream F1..F26 (last term 121393), then 65346 (= 196418 - 131072) -> accepted with err = 0, term_count = 27, expected = 55667.
- Handshake: in_valid toggling every other cycle over 1,1,2,3 -> same final state as back-to-back. Assert clear together with in_valid and data 5 in TRACK -> in_ready = 0, beat not counted, state HUNT.
- Async reset: drop reset mid-TRACK, between clock edges -> locked, term_count, err_count, expected go to 0 before the next edge; after release, HUNT works normally.

Source files
------------

// File: rtl/fibonacci_checker.sv
// Fibonacci stream checker: hunts for the 1,1 seed, then verifies each term
// against t(n) = t(n-1) + t(n-2) mod 2^WIDTH, halting on the first mismatch.
module fibonacci_checker #(
  parameter int WIDTH = 17,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] term_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SEED  = 2'd1,
    TRACK = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] TERM_ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] TERM_TWO   = WIDTH'(2);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SEEDED = CNT_W'(2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_expected;
  logic [CNT_W-1:0] r_term_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_locked;
  logic             r_err;

  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic [WIDTH-1:0] w_expected_nxt;
  logic [CNT_W-1:0] w_term_count_nxt;
  logic [CNT_W-1:0] w_err_count_nxt;
  logic             w_locked_nxt;
  logic             w_err_nxt;
  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_next_sum;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // clear gates ready combinationally so a beat presented with clear is never taken
  assign w_in_ready = (r_state != FAULT) && !clear;
  assign w_accept   = in_valid && w_in_ready;
  assign w_sum      = r_a + r_b;
  assign w_next_sum = r_b + in_data;

  always_comb begin
    w_state_nxt      = r_state;
    w_a_nxt          = r_a;
    w_b_nxt          = r_b;
    w_expected_nxt   = r_expected;
    w_term_count_nxt = r_term_count;
    w_err_count_nxt  = r_err_count;
    w_locked_nxt     = r_locked;
    w_err_nxt        = r_err;
    if (clear) begin
      w_state_nxt      = HUNT;
      w_a_nxt          = '0;
      w_b_nxt          = '0;
      w_expected_nxt   = '0;
      w_term_count_nxt = '0;
      w_locked_nxt     = 1'b0;
      w_err_nxt        = 1'b0;
    end else if (w_accept) begin
      unique case (r_state)
        HUNT: begin
          if (in_data == TERM_ONE) w_state_nxt = SEED;
        end
        SEED: begin
          if (in_data == TERM_ONE) begin
            w_state_nxt      = TRACK;
            w_a_nxt          = TERM_ONE;
            w_b_nxt          = TERM_ONE;
            w_expected_nxt   = TERM_TWO;
            w_term_count_nxt = CNT_SEEDED;
            w_locked_nxt     = 1'b1;
          end else begin
            w_state_nxt = HUNT;
          end
        end
        TRACK: begin
          // a, b and term_count stay frozen on a mismatch for post-mortem reads
          if (in_data == w_sum) begin
            w_a_nxt          = r_b;
            w_b_nxt          = in_data;
            w_expected_nxt   = w_next_sum;
            w_term_count_nxt = sat_inc(r_term_count);
          end else begin
            w_state_nxt     = FAULT;
            w_expected_nxt  = '0;
            w_locked_nxt    = 1'b0;
            w_err_nxt       = 1'b1;
            w_err_count_nxt = sat_inc(r_err_count);
          end
        end
        FAULT: begin
          w_state_nxt = FAULT;
        end
        default: begin
          w_state_nxt = HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= HUNT;
      r_a          <= '0;
      r_b          <= '0;
      r_expected   <= '0;
      r_term_count <= '0;
      r_err_count  <= '0;
      r_locked     <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_a          <= w_a_nxt;
      r_b          <= w_b_nxt;
      r_expected   <= w_expected_nxt;
      r_term_count <= w_term_count_nxt;
      r_err_count  <= w_err_count_nxt;
      r_locked     <= w_locked_nxt;
      r_err        <= w_err_nxt;
    end
  end

  assign in_ready   = w_in_ready;
  assign locked     = r_locked;
  assign err        = r_err;
  assign expected   = r_expected;
  assign term_count = r_term_count;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_fibonacci_checker.sv
// Scoreboard bench for fibonacci_checker: the driver queues the expected state
// after each beat; a monitor checks it the cycle after the beat is accepted.
module tb_fibonacci_checker;

  localparam int WIDTH = 17;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             clear = 1'b0;
  logic             in_ready;
  logic             locked;
  logic             err;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] term_count;
  logic [CNT_W-1:0] err_count;

  typedef struct packed {
    logic             lk;
    logic             er;
    logic [WIDTH-1:0] ex;
    logic [CNT_W-1:0] tc;
    logic [CNT_W-1:0] ec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic acc_q = 1'b0;
  int   checks = 0;
  int   errors = 0;

  fibonacci_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .clear     (clear),
    .locked    (locked),
    .err       (err),
    .expected  (expected),
    .term_count(term_count),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: an accept seen at a rising edge is checked on the following falling edge
  always @(posedge clk) acc_q <= in_valid && in_ready && reset;

  always @(negedge clk) begin
    if (acc_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_accept", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("locked", 32'(locked), 32'(mon_e.lk));
        chk("err", 32'(err), 32'(mon_e.er));
        chk("expected", 32'(expected), 32'(mon_e.ex));
        chk("term_count", 32'(term_count), 32'(mon_e.tc));
        chk("err_count", 32'(err_count), 32'(mon_e.ec));
      end
    end
  end

  task automatic beat(input logic [WIDTH-1:0] d, input logic lk, input logic er,
                      input logic [WIDTH-1:0] ex, input logic [CNT_W-1:0] tc,
                      input logic [CNT_W-1:0] ec);
    exp_t e;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    e = '{lk: lk, er: er, ex: ex, tc: tc, ec: ec};
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic do_clear();
    @(negedge clk);
    in_valid = 1'b0;
    clear    = 1'b1;
    #1 chk("ready_during_clear", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] p, c, s;

    // Reset state, observed before any clock edge
    #1;
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_expected", 32'(expected), 32'd0);
    chk("rst_term_count", 32'(term_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1 chk("rst_ready", 32'(in_ready), 32'd1);

    // Basic lock
    beat(1, 0, 0, 0, 0, 0);
    beat(1, 1, 0, 2, 2, 0);
    beat(2, 1, 0, 3, 3, 0);
    beat(3, 1, 0, 5, 4, 0);
    beat(5, 1, 0, 8, 5, 0);
    beat(8, 1, 0, 13, 6, 0);
    do_clear();

    // Hunting through non-seed values
    beat(7, 0, 0, 0, 0, 0);
    beat(1, 0, 0, 0, 0, 0);
    beat(4, 0, 0, 0, 0, 0);
    beat(1, 0, 0, 0, 0, 0);
    beat(1, 1, 0, 2, 2, 0);
    beat(2, 1, 0, 3, 3, 0);
    do_clear();

    // Fault: 4 where 3 is required
    beat(1, 0, 0, 0, 0, 0);
    beat(1, 1, 0, 2, 2, 0);
    beat(2, 1, 0, 3, 3, 0);
    beat(4, 0, 1, 0, 3, 1);
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 3;
      #1 chk("ready_in_fault", 32'(in_ready), 32'd0);
    end
    do_clear();
    #1;
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_locked", 32'(locked), 32'd0);
    chk("clr_err_count", 32'(err_count), 32'd1);
    chk("clr_term_count", 32'(term_count), 32'd0);
    chk("clr_ready", 32'(in_ready), 32'd1);
    beat(1, 0, 0, 0, 0, 1);
    beat(1, 1, 0, 2, 2, 1);
    beat(2, 1, 0, 3, 3, 1);
    do_clear();

    // Wrap: F1..F26, then F27 mod 2^17
    p = '0;
    c = 1;
    for (int i = 1; i <= 27; i++) begin
      s = p + c;
      if (i == 1) beat(c, 0, 0, 0, 0, 1);
      else        beat(c, 1, 0, s, CNT_W'(i), 1);
      p = c;
      c = s;
    end
    idle(1);
    #1;
    chk("wrap_expected", 32'(expected), 32'd55667);
    chk("wrap_term_count", 32'(term_count), 32'd27);
    chk("wrap_err", 32'(err), 32'd0);
    do_clear();

    // Handshake with gaps, then clear colliding with a valid beat
    beat(1, 0, 0, 0, 0, 1);
    idle(1);
    beat(1, 1, 0, 2, 2, 1);
    idle(1);
    beat(2, 1, 0, 3, 3, 1);
    idle(1);
    beat(3, 1, 0, 5, 4, 1);
    idle(1);
    @(negedge clk);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5;
    #1 chk("ready_clear_collide", 32'(in_ready), 32'd0);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("collide_locked", 32'(locked), 32'd0);
    chk("collide_term_count", 32'(term_count), 32'd0);
    chk("collide_expected", 32'(expected), 32'd0);

    // Async reset mid-TRACK, between clock edges
    beat(1, 0, 0, 0, 0, 1);
    beat(1, 1, 0, 2, 2, 1);
    beat(2, 1, 0, 3, 3, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 3;
    #2 reset = 1'b0;
    #1;
    chk("arst_locked", 32'(locked), 32'd0);
    chk("arst_term_count", 32'(term_count), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_expected", 32'(expected), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1 chk("arst_ready", 32'(in_ready), 32'd1);
    beat(1, 0, 0, 0, 0, 0);
    beat(1, 1, 0, 2, 2, 0);
    beat(2, 1, 0, 3, 3, 0);
    idle(3);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
